param_clk_divider: RTL and testbench
====================================

PARAM_CLK_DIVIDER -- requirements
Module: param_clk_divider

Interface
REQ-001 Parameter WIDTH, default 8: width of the divide-ratio datapath and counter.
REQ-002 Parameter DEFAULT_DIV, default 6: active divide ratio after reset; legal range 2 .. 2^WIDTH-1.
REQ-003 sys_clk  input  1  sole clock; all logic on its rising edge only.
REQ-004 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  1 = run divider; 0 = stop and hold idle.
REQ-006 div_load  input  1  single-cycle strobe; samples div_ratio.
REQ-007 div_ratio  input  WIDTH  requested divide ratio N.
REQ-008 clk_out  output  1  divided clock, registered.
REQ-009 tick_out  output  1  one-cycle strobe marking the start of each clk_out period, registered.
REQ-010 ratio_active  output  WIDTH  ratio currently in force.
REQ-011 pend_valid  output  1  a loaded ratio is waiting to be applied.
REQ-012 ratio_err  output  1  one-cycle flag: the last load was rejected.

Function
REQ-013 The block SHALL have two states, IDLE and RUN, plus counter cnt[WIDTH-1:0] counting 0..N-1, where N = ratio_active.
REQ-014 Let H = ceil(N/2). In RUN, after every edge, clk_out SHALL equal 1 iff cnt < H, and tick_out SHALL equal 1 iff cnt == 0.
REQ-015 Duty cycle: even N gives N/2 high and N/2 low; odd N gives (N+1)/2 high and (N-1)/2 low.
REQ-016 IDLE->RUN SHALL occur on the first edge with enable=1; that edge SHALL set cnt=0, clk_out=1 and tick_out=1, with no extra latency cycle.
REQ-017 In RUN with enable=1, cnt SHALL increment by 1 per edge and wrap from N-1 to 0; the wrap edge is the period boundary.
REQ-018 RUN->IDLE SHALL occur on the first edge with enable=0; that edge SHALL set cnt=0, clk_out=0 and tick_out=0, truncating the current phase.
REQ-019 In IDLE, outputs SHALL hold clk_out=0, tick_out=0 and cnt=0.
REQ-020 When div_load=1 and div_ratio>=2, the pending register SHALL take div_ratio and pend_valid SHALL be 1 after that edge.
REQ-021 When div_load=1 and div_ratio<2, the load SHALL be ignored, ratio_err SHALL be 1 for exactly the following cycle, and the pending and active values SHALL be unchanged.
REQ-022 A pending ratio SHALL be applied only at a period boundary (RUN wrap edge) or on the IDLE->RUN edge: ratio_active takes the pending value and pend_valid clears on that edge.
REQ-023 Ratio changes SHALL never shorten or lengthen a period already in progress; clk_out SHALL be glitch-free.
REQ-024 Simultaneous load and boundary: a load on a wrap or IDLE->RUN edge SHALL NOT be applied on that edge; the boundary uses the pending value held before the edge, and the new value applies at the next boundary.
REQ-025 A second valid load before application SHALL overwrite the pending value (last-write-wins).
REQ-026 A load while in IDLE SHALL be held pending and applied on the IDLE->RUN edge that follows.
REQ-027 The counter compare SHALL be at full WIDTH with no overflow; N = 2^WIDTH-1 SHALL work (WIDTH=8: 128 high, 127 low).

Reset
REQ-028 sys_rst_n=0 sampled on an edge SHALL, on that edge, force state=IDLE, cnt=0, clk_out=0, tick_out=0, ratio_err=0, pend_valid=0 and ratio_active=DEFAULT_DIV, regardless of enable or div_load.
REQ-029 Reset asserted mid-period SHALL discard any pending ratio; operation SHALL resume under REQ-016 on the first edge with sys_rst_n=1 and enable=1.

Verification
REQ-030 Reset, then enable=1 held (default 6): clk_out runs 3 high/3 low from the first enabled edge; tick_out is high every 6th cycle, coincident with clk_out rising.
REQ-031 In RUN at N=6, pulse div_load with div_ratio=5 at cnt=1: pend_valid=1; the current period still lasts 6 cycles; then ratio_active=5, the pattern is 3 high/2 low, and pend_valid=0.
REQ-032 Pulse div_load with div_ratio=1, then with 0: ratio_err is high one cycle after each; ratio_active and pend_valid are unchanged; clk_out is undisturbed.
REQ-033 Pulse div_load with div_ratio=4 exactly on a wrap edge: the next period is still the old N; the period after it is N=4 (2 high/2 low).
REQ-034 Drop enable during the high phase at N=7: clk_out=0 on the next edge; after re-enable, clk_out=1 and tick_out=1 on the first edge, then 4 high/3 low.
REQ-035 With a pending ratio loaded, assert sys_rst_n=0 for one edge mid-period: all outputs take reset values on that edge; after release, the divider runs at N=6 and pend_valid=0.

Source files
------------

// File: rtl/param_clk_divider.sv
// Programmable clock divider: clk_out runs at sys_clk/N with a ceil(N/2) high phase.
// Latency: first enabled edge drives clk_out=1 and tick_out=1; no warm-up cycle.
// Ratio updates are double-buffered and take effect only at period boundaries.
module param_clk_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             clk_out,
  output logic             tick_out,
  output logic [WIDTH-1:0] ratio_active,
  output logic             pend_valid,
  output logic             ratio_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] ratio_active_q, ratio_active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             ratio_err_q, ratio_err_d;

  // High-phase length ceil(N/2), formed without a carry out of WIDTH bits so
  // that N = 2^WIDTH-1 still works.
  logic [WIDTH-1:0] half_len;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_last;
  logic             boundary;

  // Next-state logic: run/idle sequencing, period counter and ratio buffering.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    clk_out_d      = clk_out_q;
    tick_d         = 1'b0;
    ratio_active_d = ratio_active_q;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    ratio_err_d    = 1'b0;
    boundary       = 1'b0;

    half_len = (ratio_active_q >> 1) + {{(WIDTH-1){1'b0}}, ratio_active_q[0]};
    cnt_inc  = cnt_q + ONE;
    cnt_last = ratio_active_q - ONE;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (enable) begin
          state_d   = RUN;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          boundary  = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // Truncate the current phase immediately.
          state_d   = IDLE;
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end else if (cnt_q == cnt_last) begin
          cnt_d     = '0;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          boundary  = 1'b1;
        end else begin
          cnt_d     = cnt_inc;
          clk_out_d = (cnt_inc < half_len);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase

    // The boundary consumes the value pending before this edge; the new period
    // therefore starts with a consistent N for both compare and wrap.
    if (boundary && pend_valid_q) begin
      ratio_active_d = pend_q;
      pend_valid_d   = 1'b0;
    end

    // A load on a boundary edge is evaluated after the apply above so that it
    // stays pending for the following boundary.
    if (div_load) begin
      if (div_ratio >= TWO) begin
        pend_d       = div_ratio;
        pend_valid_d = 1'b1;
      end else begin
        ratio_err_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      clk_out_q      <= 1'b0;
      tick_q         <= 1'b0;
      ratio_active_q <= RESET_DIV;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      ratio_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      clk_out_q      <= clk_out_d;
      tick_q         <= tick_d;
      ratio_active_q <= ratio_active_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      ratio_err_q    <= ratio_err_d;
    end
  end

  assign clk_out      = clk_out_q;
  assign tick_out     = tick_q;
  assign ratio_active = ratio_active_q;
  assign pend_valid   = pend_valid_q;
  assign ratio_err    = ratio_err_q;

endmodule

// File: tb/tb_param_clk_divider.sv
// Bench for param_clk_divider: directed scenarios plus random traffic.
// A phase-based reference model is compared against the outputs every cycle.
// Directed scenarios also pin literal waveforms to anchor the model.
module tb_param_clk_divider;

  localparam int WIDTH = 8;
  localparam int DEF   = 6;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             enable;
  logic             div_load;
  logic [WIDTH-1:0] div_ratio;
  logic             clk_out;
  logic             tick_out;
  logic [WIDTH-1:0] ratio_active;
  logic             pend_valid;
  logic             ratio_err;

  int vectors     = 0;
  int miscompares = 0;

  param_clk_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .enable       (enable),
    .div_load     (div_load),
    .div_ratio    (div_ratio),
    .clk_out      (clk_out),
    .tick_out     (tick_out),
    .ratio_active (ratio_active),
    .pend_valid   (pend_valid),
    .ratio_err    (ratio_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a period is a run of cycles numbered from 0 by 'phase';
  // the output is high for the first ceil(N/2) of them.
  bit m_running = 0;
  int m_phase   = 0;
  int m_n       = DEF;
  int m_pend    = 0;
  bit m_pend_v  = 0;
  bit m_err     = 0;

  always @(posedge sys_clk) begin
    bit start;
    start = 0;
    if (!sys_rst_n) begin
      m_running = 0; m_phase = 0; m_n = DEF; m_pend_v = 0; m_err = 0;
    end else begin
      m_err = div_load && (div_ratio < 2);
      if (!m_running) begin
        if (enable) begin m_running = 1; m_phase = 0; start = 1; end
      end else if (!enable) begin
        m_running = 0; m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
        if (m_phase == m_n) begin m_phase = 0; start = 1; end
      end
      if (start && m_pend_v) begin m_n = m_pend; m_pend_v = 0; end
      if (div_load && div_ratio >= 2) begin m_pend = int'(div_ratio); m_pend_v = 1; end
    end
    #1;
    chk("clk_out",      int'(clk_out),      int'(m_running && (m_phase < (m_n + 1) / 2)));
    chk("tick_out",     int'(tick_out),     int'(m_running && (m_phase == 0)));
    chk("ratio_active", int'(ratio_active), m_n);
    chk("pend_valid",   int'(pend_valid),   int'(m_pend_v));
    chk("ratio_err",    int'(ratio_err),    int'(m_err));
  end

  // Advance one edge and sample outputs on the following falling edge.
  task automatic step(output logic c, output logic t);
    @(negedge sys_clk);
    c = clk_out;
    t = tick_out;
  endtask

  task automatic wait_tick();
    bit found;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge sys_clk);
      if (tick_out) found = 1;
    end
    chk("wait_tick_timeout", int'(found), 1);
  endtask

  task automatic collect(input int n, output logic [15:0] cp, output logic [15:0] tp);
    logic c, t;
    cp = '0; tp = '0;
    for (int i = 0; i < n; i++) begin
      step(c, t);
      cp = {cp[14:0], c};
      tp = {tp[14:0], t};
    end
  endtask

  initial begin
    logic [15:0] cp, tp;
    logic c, t;
    int hi;

    sys_rst_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_ratio = '0;
    step(c, t); step(c, t);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick_out), 0);
    chk("rst_ratio", int'(ratio_active), 6);
    chk("rst_pend", int'(pend_valid), 0);
    chk("rst_err", int'(ratio_err), 0);

    // Default ratio 6: 3 high / 3 low, tick coincident with each rise.
    sys_rst_n = 1'b1; enable = 1'b1;
    collect(12, cp, tp);
    chk("n6_clk_pattern", int'(cp[11:0]), int'(12'b111000111000));
    chk("n6_tick_pattern", int'(tp[11:0]), int'(12'b100000100000));

    // Load 5 at cnt=1: current period keeps 6, then 3 high / 2 low.
    wait_tick();
    step(c, t);
    div_load = 1'b1; div_ratio = 8'd5;
    step(c, t);
    div_load = 1'b0;
    chk("load5_pend", int'(pend_valid), 1);
    chk("load5_old_n", int'(ratio_active), 6);
    collect(13, cp, tp);
    chk("load5_clk_pattern", int'(cp[12:0]), int'(13'b0001110011100));
    chk("load5_ratio", int'(ratio_active), 5);
    chk("load5_pend_clr", int'(pend_valid), 0);

    // Illegal ratios 1 and 0 raise a one-cycle error and change nothing.
    for (int r = 1; r >= 0; r--) begin
      div_load = 1'b1; div_ratio = WIDTH'(r);
      step(c, t);
      div_load = 1'b0;
      chk("bad_load_err", int'(ratio_err), 1);
      chk("bad_load_ratio", int'(ratio_active), 5);
      chk("bad_load_pend", int'(pend_valid), 0);
      step(c, t);
      chk("bad_load_err_clr", int'(ratio_err), 0);
    end

    // Load 4 exactly on a wrap edge: next period still N=5, then N=4.
    wait_tick();
    for (int i = 0; i < 4; i++) step(c, t);
    div_load = 1'b1; div_ratio = 8'd4;
    cp = '0;
    for (int i = 0; i < 9; i++) begin
      step(c, t);
      div_load = 1'b0;
      cp = {cp[14:0], c};
    end
    chk("wrap_load_pattern", int'(cp[8:0]), int'(9'b111001100));

    // Random traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge sys_clk);
      sys_rst_n = ($urandom_range(0, 499) != 0);
      enable    = ($urandom_range(0, 19) != 0);
      div_load  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       div_ratio = WIDTH'($urandom_range(0, 3));
        1:       div_ratio = WIDTH'($urandom_range(2, 12));
        2:       div_ratio = WIDTH'($urandom_range(240, 255));
        default: div_ratio = WIDTH'($urandom);
      endcase
    end
    sys_rst_n = 1'b1; enable = 1'b1; div_load = 1'b0;

    // N=7: drop enable in the high phase, then restart at 4 high / 3 low.
    div_load = 1'b1; div_ratio = 8'd7;
    step(c, t);
    div_load = 1'b0;
    wait_tick(); wait_tick();
    chk("n7_ratio", int'(ratio_active), 7);
    step(c, t);
    enable = 1'b0;
    step(c, t);
    chk("n7_stop_clk", int'(c), 0);
    chk("n7_stop_tick", int'(t), 0);
    enable = 1'b1;
    collect(7, cp, tp);
    chk("n7_clk_pattern", int'(cp[6:0]), int'(7'b1111000));
    chk("n7_tick_pattern", int'(tp[6:0]), int'(7'b1000000));

    // Maximum ratio 255: 128 high within a 255-cycle period.
    div_load = 1'b1; div_ratio = 8'd255;
    step(c, t);
    div_load = 1'b0;
    wait_tick(); wait_tick();
    chk("n255_ratio", int'(ratio_active), 255);
    hi = int'(clk_out);
    for (int i = 0; i < 254; i++) begin
      step(c, t);
      hi += int'(c);
    end
    chk("n255_high_cycles", hi, 128);
    step(c, t);
    chk("n255_period_tick", int'(t), 1);

    // Reset mid-period with a pending ratio discards it and restarts at N=6.
    div_load = 1'b1; div_ratio = 8'd9;
    step(c, t);
    div_load = 1'b0;
    chk("rst_mid_pend_set", int'(pend_valid), 1);
    step(c, t);
    sys_rst_n = 1'b0;
    step(c, t);
    chk("rst_mid_clk", int'(clk_out), 0);
    chk("rst_mid_tick", int'(tick_out), 0);
    chk("rst_mid_ratio", int'(ratio_active), 6);
    chk("rst_mid_pend", int'(pend_valid), 0);
    chk("rst_mid_err", int'(ratio_err), 0);
    sys_rst_n = 1'b1;
    collect(6, cp, tp);
    chk("rst_mid_pattern", int'(cp[5:0]), int'(6'b111000));
    chk("rst_mid_pend_after", int'(pend_valid), 0);

    @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
